// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
//
// Bundles the two handshakes of the bit-serial adder sequencer, plus its status.
//
//   Operand side (producer -> block):
//     start_valid  producer has operands
//     start_ready  block can accept operands
//     a, b         WIDTH-bit operands
//     cin          carry-in
//
//   Result side (block -> consumer):
//     sum          WIDTH-bit result
//     carry        carry-out
//     done_valid   result available
//     done_ready   consumer takes result
//
//   Status:
//     busy         operation in progress or result pending
//
// Modports:
//   master  the producer/consumer environment
//   slave   the sequencer itself
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;

  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             done_valid;
  logic             done_ready;

  logic             busy;

  modport master (
    output start_valid,
    output a,
    output b,
    output cin,
    output done_ready,
    input  start_ready,
    input  sum,
    input  carry,
    input  done_valid,
    input  busy
  );

  modport slave (
    input  start_valid,
    input  a,
    input  b,
    input  cin,
    input  done_ready,
    output start_ready,
    output sum,
    output carry,
    output done_valid,
    output busy
  );

endinterface

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//
// Sequencer for a bit-serial adder. Operands are captured through a
// valid/ready handshake, then a single one-bit full-adder slice (two half
// adders plus a carry flop) is stepped LSB-first for WIDTH cycles. The result
// is offered through a second valid/ready handshake.
//
// Handshakes: a transfer happens on a rising edge where both valid and ready
// are high. Valid does not depend on ready. start_ready is high only in IDLE,
// and done_valid is high only in DONE. Because of that, a new operand accept
// can never coincide with a result being taken.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (clears every register)
//   bus        serial_add_ctrl_if.slave (operand/result handshakes, busy)
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Parameters:
//   WIDTH      operand/sum width, legal range 2..64
//
// Timing: operands accepted at edge k give done_valid from edge k+WIDTH.
// Back-to-back issue interval is WIDTH+2 cycles with done_ready held high.
// -----------------------------------------------------------------------------
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_add_ctrl_if.slave     bus,
  output logic [1:0]           state_dbg
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_sr;
  logic             c;
  logic [CNT_W-1:0] cnt;

  // One-bit full-adder slice built from two half adders. The first half adder
  // combines the operand bits; the second folds in the carry flop.
  logic ha_p;
  logic ha_g;
  logic s_bit;
  logic co_bit;

  assign ha_p   = op_a[0] ^ op_b[0];
  assign ha_g   = op_a[0] & op_b[0];
  assign s_bit  = ha_p ^ c;
  assign co_bit = ha_g | (ha_p & c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      sum_sr <= '0;
      c      <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // start_ready is IDLE itself, so start_valid alone completes the
          // handshake here.
          if (bus.start_valid) begin
            op_a   <= bus.a;
            op_b   <= bus.b;
            c      <= bus.cin;
            sum_sr <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end

        RUN: begin
          // Sum bits enter at the MSB and move toward bit 0, so after WIDTH
          // steps the first (LSB) result bit lands in sum_sr[0].
          sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
          op_a   <= {1'b0, op_a[WIDTH-1:1]};
          op_b   <= {1'b0, op_b[WIDTH-1:1]};
          c      <= co_bit;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state <= DONE;
          end
        end

        DONE: begin
          // sum_sr and c are left untouched so the outputs hold their value
          // after the result is taken.
          if (bus.done_ready) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake and status flags are pure decodes of the state register.
  assign bus.start_ready = (state == IDLE);
  assign bus.done_valid  = (state == DONE);
  assign bus.busy        = (state == RUN) || (state == DONE);

  // Result is driven straight from registers.
  assign bus.sum   = sum_sr;
  assign bus.carry = c;

  assign state_dbg = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
//
// Directed bench for serial_add_ctrl. Two instances: WIDTH=8 for the directed
// scenarios and WIDTH=4 for the exhaustive sweep. Inputs change and outputs
// are sampled on the falling edge; the DUT updates on the rising edge.
// Expected {carry, sum} values are pushed when operands are driven and popped
// when done_valid is observed.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  serial_add_ctrl_if #(.WIDTH(8)) s8 ();
  serial_add_ctrl_if #(.WIDTH(4)) s4 ();
  logic [1:0] st8;
  logic [1:0] st4;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .bus       (s8),
    .state_dbg (st8)
  );

  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .bus       (s4),
    .state_dbg (st4)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [8:0] exp8_q[$];
  logic [4:0] exp4_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  // One full WIDTH=8 operation with done_ready held high. Checks accept-to-done
  // latency, the number of busy cycles and the result.
  task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                     input logic tc);
    int lat;
    int busy_n;
    logic [8:0] e;
    check({tag, "_ready"}, s8.start_ready, 1);
    s8.a           = ta;
    s8.b           = tb_v;
    s8.cin         = tc;
    s8.start_valid = 1'b1;
    s8.done_ready  = 1'b1;
    exp8_q.push_back({1'b0, ta} + {1'b0, tb_v} + {8'd0, tc});
    tick();
    s8.start_valid = 1'b0;
    s8.a           = 8'($urandom);
    s8.b           = 8'($urandom);
    s8.cin         = 1'($urandom);
    lat    = 0;
    busy_n = 0;
    while (!s8.done_valid && lat < 64) begin
      if (s8.busy) busy_n++;
      tick();
      lat++;
    end
    check({tag, "_done_valid"}, s8.done_valid, 1);
    check({tag, "_latency"}, lat, 8);
    if (s8.busy) busy_n++;
    if (exp8_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp8_q.pop_front();
      check({tag, "_result"}, {s8.carry, s8.sum}, e);
    end
    tick();
    check({tag, "_busy_cycles"}, busy_n, 9);
    check({tag, "_idle_after"}, {s8.start_ready, s8.done_valid, s8.busy}, 3'b100);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    int last_acc;
    logic [8:0] e8;
    logic [4:0] e4;
    logic [8:0] vv;
    logic seen;

    rst            = 1'b1;
    s8.start_valid = 1'b1;
    s8.a           = 8'h55;
    s8.b           = 8'h66;
    s8.cin         = 1'b1;
    s8.done_ready  = 1'b0;
    s4.start_valid = 1'b0;
    s4.a           = '0;
    s4.b           = '0;
    s4.cin         = 1'b0;
    s4.done_ready  = 1'b0;

    // 1. Reset for two edges with start_valid high: nothing accepted.
    tick();
    tick();
    check("t1_start_ready", s8.start_ready, 1);
    check("t1_done_valid", s8.done_valid, 0);
    check("t1_busy", s8.busy, 0);
    check("t1_sum", s8.sum, 8'h00);
    check("t1_carry", s8.carry, 0);
    check("t1_state", st8, 2'd0);
    check("t1_w4_idle", {s4.start_ready, s4.done_valid, s4.busy, s4.sum, s4.carry}, 8'b1000_0000);
    rst            = 1'b0;
    s8.start_valid = 1'b0;
    tick();
    check("t1_no_accept", {s8.start_ready, s8.busy}, 2'b10);

    // 2. Carry ripples through all bits.
    op8("t2", 8'hFF, 8'h01, 1'b0);

    // 3. Mixed patterns, including carry-in.
    op8("t3a", 8'hA5, 8'h5A, 1'b1);
    op8("t3b", 8'h12, 8'h34, 1'b0);

    // 4. Back-pressure: result held while done_ready is low.
    s8.a           = 8'h3C;
    s8.b           = 8'h99;
    s8.cin         = 1'b1;
    s8.start_valid = 1'b1;
    s8.done_ready  = 1'b0;
    exp8_q.push_back(9'h0D6);
    tick();
    s8.start_valid = 1'b0;
    n = 0;
    while (!s8.done_valid && n < 64) begin
      tick();
      n++;
    end
    check("t4_done_valid", s8.done_valid, 1);
    e8 = (exp8_q.size() != 0) ? exp8_q.pop_front() : 9'h1FF;
    for (int i = 0; i < 5; i++) begin
      s8.start_valid = i[0];
      s8.a           = 8'($urandom);
      check("t4_hold_result", {s8.carry, s8.sum}, e8);
      check("t4_hold_flags", {s8.start_ready, s8.done_valid, s8.busy}, 3'b011);
      tick();
    end
    check("t4_hold_last", {s8.carry, s8.sum, s8.done_valid}, {e8, 1'b1});
    s8.start_valid = 1'b0;
    s8.done_ready  = 1'b1;
    tick();
    check("t4_released", {s8.start_ready, s8.done_valid, s8.busy}, 3'b100);
    check("t4_result_kept", {s8.carry, s8.sum}, e8);

    // 5. Reset during RUN discards the operation.
    s8.a           = 8'h0F;
    s8.b           = 8'h01;
    s8.cin         = 1'b0;
    s8.start_valid = 1'b1;
    tick();
    s8.start_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t5_running", st8, 2'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_after_rst", {s8.start_ready, s8.done_valid, s8.busy}, 3'b100);
    check("t5_cleared", {s8.carry, s8.sum}, 9'h000);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (s8.done_valid) seen = 1'b1;
    end
    check("t5_no_result", seen, 0);
    op8("t5", 8'h03, 8'h04, 1'b0);

    // 6. WIDTH=4 exhaustive sweep, back-to-back.
    last_acc = 0;
    for (int v = 0; v < 512; v++) begin
      vv = v[8:0];
      n  = 0;
      while (!s4.start_ready && n < 20) begin
        tick();
        n++;
      end
      if (v > 0) check("t6_interval", cyc - last_acc, 6);
      last_acc       = cyc;
      s4.cin         = vv[8];
      s4.a           = vv[7:4];
      s4.b           = vv[3:0];
      s4.start_valid = 1'b1;
      s4.done_ready  = 1'b1;
      exp4_q.push_back({1'b0, vv[7:4]} + {1'b0, vv[3:0]} + {4'd0, vv[8]});
      tick();
      s4.start_valid = 1'b0;
      n = 0;
      while (!s4.done_valid && n < 20) begin
        tick();
        n++;
      end
      check("t6_done_valid", s4.done_valid, 1);
      e4 = (exp4_q.size() != 0) ? exp4_q.pop_front() : 5'h1F;
      check("t6_result", {s4.carry, s4.sum}, e4);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
Sequencer for a bit-serial adder. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It then drives a single one-bit full-adder slice (half-adder pair plus carry flop) LSB-first for WIDTH cycles and presents sum and carry-out through a second valid/ready handshake. It sits between an operand producer and a result consumer, and trades latency for a one-bit datapath.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start_valid  input  1  producer has operands
start_ready  output  1  block can accept operands (high only in IDLE)
a  input  WIDTH  operand A, sampled only on accept
b  input  WIDTH  operand B, sampled only on accept
cin  input  1  carry-in, sampled only on accept
sum  output  WIDTH  result; meaningful only while done_valid=1
carry  output  1  carry-out; meaningful only while done_valid=1
done_valid  output  1  result available
done_ready  input  1  consumer takes result
busy  output  1  high in RUN and DONE

Behaviour:
- Single clock domain. All state is updated on the rising edge of clk.
- Reset: when rst=1 at an edge, the block goes to IDLE and clears every register. After reset: sum=0, carry=0, done_valid=0, busy=0, start_ready=1.
  - Reset overrides any handshake in the same cycle.
  - Reset in RUN or DONE discards the operation with no result.
- Registers:
  - op_a and op_b shift registers, WIDTH bits each.
  - sum_sr shift register, WIDTH bits.
  - c, the one-bit carry flop.
  - cnt, $clog2(WIDTH)+1 bits.
  - state.
- FSM states IDLE, RUN, DONE. Outputs are decoded from state: start_ready=(IDLE), done_valid=(DONE), busy=(RUN or DONE).
- IDLE:
  - On start_valid & start_ready: op_a<=a, op_b<=b, c<=cin, sum_sr<=0, cnt<=0, state<=RUN.
  - Otherwise hold; a, b and cin are ignored.
- RUN, every cycle:
  - s = op_a[0]^op_b[0]^c
  - co = majority(op_a[0], op_b[0], c)
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}
  - op_a and op_b shift right with 0 fill
  - c <= co
  - cnt <= cnt+1
  - When cnt==WIDTH-1 the block takes this last bit step and then goes to DONE.
  - start_valid is ignored throughout RUN.
- DONE:
  - sum=sum_sr and carry=c, held stable.
  - On done_ready: state<=IDLE. sum and carry keep their values but are no longer valid.
  - start_valid is ignored (start_ready=0), so done_ready and start_valid in the same cycle do not overlap. A new accept happens at the earliest one cycle after the DONE->IDLE transition.
- Latency:
  - Operands accepted at edge k give done_valid=1 from edge k+WIDTH onward.
  - The block spends exactly WIDTH cycles in RUN.
  - Minimum issue interval is WIDTH+2 cycles with done_ready held at 1.
- Arithmetic: {carry, sum} == a + b + cin, modulo 2^(WIDTH+1); there is no overflow flag.
- Back-pressure: DONE is held indefinitely while done_ready=0, with outputs constant.
- No X propagation: sum and carry are driven from registers only.

Test Plan:
1. Assert rst for 2 cycles, then release -> start_ready=1, done_valid=0, busy=0, sum=0, carry=0. Drive start_valid=1 with rst=1 -> no accept.
2. WIDTH=8: a=8'hFF, b=8'h01, cin=0, done_ready=1 -> done_valid rises exactly 8 edges after accept with sum=8'h00, carry=1. busy is high for 9 cycles.
3. WIDTH=8: a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, carry=1. Then a=8'h12, b=8'h34, cin=0 -> sum=8'h46, carry=0.
4. Back-pressure: complete an op with done_ready=0 for 5 cycles while pulsing start_valid -> sum and carry constant, start_ready=0, no new accept. Raise done_ready -> IDLE on the next edge.
5. Reset mid-RUN: accept a=8'h0F, b=8'h01, then assert rst after 3 RUN cycles -> IDLE, done_valid never rises. Next op a=8'h03, b=8'h04 -> sum=8'h07, carry=0.
6. WIDTH=4 exhaustive: all 512 (a, b, cin) combinations back-to-back -> {carry, sum}==a+b+cin each time; issue interval = 6 cycles.
